uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that accepts parallel bytes over a valid/ready handshake and shifts them onto the serial line, one bit per `clk_baud` cycle. It feeds the line consumed by `uart_rx`, with frame format start(0), data MSB first, even parity, stop(1). A one-entry holding register allows back-to-back frames with no idle gap.

## Interface
- `WIDTH`, default 8: data bits per frame.
- `clk_baud`  in  1  bit-rate clock; one serial bit per rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_data`  in  WIDTH  byte to send; sampled on accept.
- `tx_valid`  in  1  producer has a byte on `tx_data`.
- `tx_ready`  out  1  holding register empty; byte accepted when `tx_valid && tx_ready` at a `clk_baud` rising edge.
- `tx_out`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  high while a frame is on the line (START through STOP).
- `tx_done`  out  1  one-cycle pulse after each stop bit completes.

## Operation
- Reset values: `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, state IDLE, holding register empty, bit counter 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE with accept: the byte loads straight into the shifter, bypassing the holding register. State goes to START and `tx_out` is 0 from the same edge.
- START → DATA: shift out WIDTH bits MSB first, with a counter running 0..WIDTH-1.
- DATA after bit WIDTH-1 → PARITY: `tx_out` = XOR-reduce of the data byte, so the total count of ones is even.
- PARITY → STOP: `tx_out`=1.
- STOP, holding register full: the holding register moves into the shifter, state goes to START, and the holding register empties. There is no idle bit between frames.
- STOP, holding register empty: state goes to IDLE.
- Accept while busy: the byte goes into the holding register and `tx_ready` drops to 0 at that edge.
- Holding register drained on the same edge that `tx_valid` is high with `tx_ready`=0: that byte is not accepted. `tx_ready` returns to 1 on the next cycle.
- `tx_data` changing after accept has no effect on the frame in flight.
- `tx_done` asserts on the edge that leaves STOP, whether the next state is IDLE or START.
- Reset mid-frame: `tx_out` goes to 1 immediately, the frame is truncated and the held byte is discarded.

## Timing
- Accept at edge k, from IDLE:
  - edge k: start bit.
  - edges k+1..k+WIDTH: data bits.
  - edge k+WIDTH+1: parity.
  - edge k+WIDTH+2: stop.
  - edge k+WIDTH+3: `tx_done`=1 for one cycle.
- Frame length is WIDTH+3 cycles, 11 at default.
- Back-to-back frames: the next start bit is driven at edge k+WIDTH+3, at the same edge as the `tx_done` pulse.
- `tx_busy` is high from edge k until edge k+WIDTH+3, and stays high if a held byte follows.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state present, frame is WIDTH+3 bits, matching `uart_rx`.
- `UART_TX_PARITY_EN` undefined: PARITY state and parity logic removed, DATA goes directly to STOP, frame is WIDTH+2 bits. All other timing shifts one cycle earlier.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - `UART_LINE_IDLE`=1'b1, `UART_START_BIT`=1'b0, `UART_STOP_BIT`=1'b1.
  - Default width constant 8, shared with `uart_rx`.
- One sub-module, `uart_tx_hold`: a one-entry holding register with valid/ready in and load/empty out.
- The FSM, shifter and bit counter stay in `uart_tx`.

## Test plan
- Reset, then send 0xA5 from IDLE → `tx_out` over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; `tx_done` pulses at cycle 11.
- Send 0x01 → parity bit 1, frame 0,0,0,0,0,0,0,0,1,1,1.
- `tx_valid` held high with 0x3C then 0xC3 → second start bit immediately follows the first stop bit; `tx_ready` 0 after the second accept and 1 again one cycle after the handoff; 22 contiguous frame bits.
- Drive a third byte 0x55 while the holding register is full → no accept until `tx_ready`=1; all three frames are correct and in order.
- Assert `rst`=0 at data bit 4 of 0xFF with 0x00 held → `tx_out`=1 at once, `tx_busy`=0, `tx_ready`=1; 0x00 is never transmitted.
- Build without `UART_TX_PARITY_EN` and send 0xA5 → 10-bit frame 0,1,0,1,0,0,1,0,1,1; `tx_done` at cycle 10.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line-level constants and the
// default frame width used by both the transmitter and receiver.
package uart_pkg;

   localparam int UART_WIDTH_DEFAULT = 8;

   localparam logic UART_LINE_IDLE = 1'b1;
   localparam logic UART_START_BIT = 1'b0;
   localparam logic UART_STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   // Width of a counter that must reach width-1; at least one bit.
   function automatic int uart_cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register for the UART transmitter. A byte is written when
// wr_valid is high and the entry is empty; load empties it as the shifter
// takes the byte.
module uart_tx_hold
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_WIDTH_DEFAULT
) (
   input  logic             clk_baud,
   input  logic             rst,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             load,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   logic             full_q;
   logic             full_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Load and write never coincide: a write needs the entry empty, a load needs it full.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (load) begin
         full_d = 1'b0;
      end
      if (wr_valid && !full_q) begin
         full_d = 1'b1;
         data_d = wr_data;
      end
   end

   // Holding register state; reset discards any held byte.
   always_ff @(posedge clk_baud or negedge rst) begin
      if (!rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign wr_ready = !full_q;
   assign empty    = !full_q;
   assign rd_data  = data_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data MSB first, optional even parity, stop bit,
// one bit per clk_baud edge. A held byte follows the stop bit with no idle gap.
// Define UART_TX_PARITY_EN to include the parity bit (WIDTH+3 bit frame);
// without it the frame is WIDTH+2 bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_WIDTH_DEFAULT
) (
   input  logic             clk_baud,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_out,
   output logic             tx_busy,
   output logic             tx_done
);

   localparam int             CW       = uart_cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   uart_state_e      state_q;
   uart_state_e      state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             tx_out_q;
   logic             tx_out_d;
   logic             done_q;
   logic             done_d;
`ifdef UART_TX_PARITY_EN
   logic             parity_q;
   logic             parity_d;
`endif

   logic             hold_wr_valid;
   logic             hold_wr_ready;
   logic             hold_load;
   logic [WIDTH-1:0] hold_data;
   logic             hold_empty;
   logic             start_frame;
   logic [WIDTH-1:0] next_byte;

   // In IDLE an accepted byte bypasses the holding register straight into the shifter.
   assign hold_wr_valid = tx_valid && (state_q != IDLE);

   uart_tx_hold #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk_baud (clk_baud),
      .rst      (rst),
      .wr_data  (tx_data),
      .wr_valid (hold_wr_valid),
      .wr_ready (hold_wr_ready),
      .load     (hold_load),
      .rd_data  (hold_data),
      .empty    (hold_empty)
   );

   // Next-state, shifter, counter and registered line value for the frame FSM.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      tx_out_d    = tx_out_q;
      done_d      = 1'b0;
      hold_load   = 1'b0;
      start_frame = 1'b0;
      next_byte   = tx_data;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      case (state_q)
         IDLE: begin
            tx_out_d = UART_LINE_IDLE;
            if (!hold_empty) begin
               start_frame = 1'b1;
               next_byte   = hold_data;
               hold_load   = 1'b1;
            end else if (tx_valid) begin
               start_frame = 1'b1;
               next_byte   = tx_data;
            end
         end
         START: begin
            state_d  = DATA;
            tx_out_d = shift_q[WIDTH-1];
            shift_d  = shift_q << 1;
            cnt_d    = '0;
         end
         DATA: begin
            if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
               state_d  = PARITY;
               tx_out_d = parity_q;
`else
               state_d  = STOP;
               tx_out_d = UART_STOP_BIT;
`endif
            end else begin
               tx_out_d = shift_q[WIDTH-1];
               shift_d  = shift_q << 1;
               cnt_d    = cnt_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            state_d  = STOP;
            tx_out_d = UART_STOP_BIT;
         end
`endif
         STOP: begin
            done_d = 1'b1;
            if (!hold_empty) begin
               start_frame = 1'b1;
               next_byte   = hold_data;
               hold_load   = 1'b1;
            end else begin
               state_d  = IDLE;
               tx_out_d = UART_LINE_IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            tx_out_d = UART_LINE_IDLE;
         end
      endcase

      if (start_frame) begin
         state_d  = START;
         shift_d  = next_byte;
         cnt_d    = '0;
         tx_out_d = UART_START_BIT;
`ifdef UART_TX_PARITY_EN
         parity_d = ^next_byte;
`endif
      end
   end

   // Frame state registers; reset truncates any frame and drives the line idle.
   always_ff @(posedge clk_baud or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         tx_out_q <= UART_LINE_IDLE;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         tx_out_q <= tx_out_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign tx_ready = hold_wr_ready;
   assign tx_out   = tx_out_q;
   assign tx_busy  = (state_q != IDLE);
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of single frames from IDLE, then
// back-to-back frames through the holding register and a mid-frame reset.
// Expected frames adapt to whether UART_TX_PARITY_EN is defined.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   logic       clk_baud = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_out;
   logic       tx_busy;
   logic       tx_done;

   int tests_run    = 0;
   int tests_failed = 0;

   // Frames are written in transmission order, first bit in the MSB.
   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame_par;
      logic [9:0]  frame_nopar;
   } vec_t;

   vec_t vecs [6];

   uart_tx #(
      .WIDTH (8)
   ) dut (
      .clk_baud (clk_baud),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_out   (tx_out),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   // Baud clock.
   always #5 clk_baud = ~clk_baud;

   // Run-away guard.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [10:0] expectedFrame(input vec_t v);
`ifdef UART_TX_PARITY_EN
      return v.frame_par;
`else
      return {1'b0, v.frame_nopar};
`endif
   endfunction

   // Send one byte from IDLE and check the whole frame plus the done pulse.
   task automatic applyStimulus(input vec_t v, input int idx);
      logic [10:0] got;
      got = '0;
      @(negedge clk_baud);
      tx_data  = v.data;
      tx_valid = 1'b1;
      @(posedge clk_baud);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk_baud);
         if (i == 0) begin
            tx_valid = 1'b0;
            tx_data  = ~v.data;
            checkOutput($sformatf("busy_in_frame_%0d", idx), 64'(tx_busy), 64'd1);
         end
         got = {got[9:0], tx_out};
      end
      checkOutput($sformatf("frame_%0d_%02h", idx, v.data), 64'(got), 64'(expectedFrame(v)));
      @(negedge clk_baud);
      checkOutput($sformatf("done_pulse_%0d", idx), 64'(tx_done), 64'd1);
      checkOutput($sformatf("busy_after_%0d", idx), 64'(tx_busy), 64'd0);
      @(negedge clk_baud);
      checkOutput($sformatf("done_clear_%0d", idx), 64'(tx_done), 64'd0);
   endtask

   initial begin
      logic [32:0] got3;
      logic [32:0] exp3;
      logic        line_clean;

      vecs[0] = '{8'hA5, 11'b0_10100101_0_1, 10'b0_10100101_1};
      vecs[1] = '{8'h01, 11'b0_00000001_1_1, 10'b0_00000001_1};
      vecs[2] = '{8'hFF, 11'b0_11111111_0_1, 10'b0_11111111_1};
      vecs[3] = '{8'h00, 11'b0_00000000_0_1, 10'b0_00000000_1};
      vecs[4] = '{8'h80, 11'b0_10000000_1_1, 10'b0_10000000_1};
      vecs[5] = '{8'h6B, 11'b0_01101011_1_1, 10'b0_01101011_1};

      rst      = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      repeat (3) @(negedge clk_baud);
      checkOutput("reset_tx_out", 64'(tx_out), 64'd1);
      checkOutput("reset_tx_ready", 64'(tx_ready), 64'd1);
      checkOutput("reset_tx_busy", 64'(tx_busy), 64'd0);
      checkOutput("reset_tx_done", 64'(tx_done), 64'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk_baud);
      checkOutput("idle_line", 64'(tx_out), 64'd1);

      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v], v);
      end

      // Back-to-back: 0x3C bypasses, 0xC3 is held, 0x55 waits for a free slot.
`ifdef UART_TX_PARITY_EN
      exp3 = {11'b0_00111100_0_1, 11'b0_11000011_0_1, 11'b0_01010101_0_1};
`else
      exp3 = {3'b000, 10'b0_00111100_1, 10'b0_11000011_1, 10'b0_01010101_1};
`endif
      got3 = '0;
      @(negedge clk_baud);
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(posedge clk_baud);
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk_baud);
         got3 = {got3[31:0], tx_out};
         if (i == 0) begin
            checkOutput("ready_after_bypass", 64'(tx_ready), 64'd1);
            tx_data = 8'hC3;
         end else if (i == 1) begin
            checkOutput("ready_after_hold", 64'(tx_ready), 64'd0);
            tx_data = 8'h55;
         end else if (i == FRAME - 1) begin
            checkOutput("ready_full_at_stop", 64'(tx_ready), 64'd0);
         end else if (i == FRAME) begin
            checkOutput("done_first_handoff", 64'(tx_done), 64'd1);
            checkOutput("busy_first_handoff", 64'(tx_busy), 64'd1);
            checkOutput("ready_after_handoff", 64'(tx_ready), 64'd1);
         end else if (i == FRAME + 1) begin
            checkOutput("ready_third_accept", 64'(tx_ready), 64'd0);
            tx_valid = 1'b0;
            tx_data  = 8'h00;
         end else if (i == 2 * FRAME) begin
            checkOutput("done_second_handoff", 64'(tx_done), 64'd1);
            checkOutput("busy_second_handoff", 64'(tx_busy), 64'd1);
         end
      end
      checkOutput("three_frames", 64'(got3), 64'(exp3));
      @(negedge clk_baud);
      checkOutput("done_third", 64'(tx_done), 64'd1);
      checkOutput("busy_after_third", 64'(tx_busy), 64'd0);

      // Mid-frame reset with a byte held: the held byte must never appear.
      repeat (2) @(negedge clk_baud);
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      @(posedge clk_baud);
      @(negedge clk_baud);
      tx_data = 8'h00;
      @(negedge clk_baud);
      tx_valid = 1'b0;
      checkOutput("ready_held_before_reset", 64'(tx_ready), 64'd0);
      repeat (4) @(negedge clk_baud);
      rst = 1'b0;
      #1;
      checkOutput("midreset_tx_out", 64'(tx_out), 64'd1);
      checkOutput("midreset_tx_busy", 64'(tx_busy), 64'd0);
      checkOutput("midreset_tx_ready", 64'(tx_ready), 64'd1);
      checkOutput("midreset_tx_done", 64'(tx_done), 64'd0);
      @(negedge clk_baud);
      rst = 1'b1;
      line_clean = 1'b1;
      for (int i = 0; i < FRAME + 4; i++) begin
         @(negedge clk_baud);
         line_clean = line_clean & tx_out & ~tx_busy;
      end
      checkOutput("held_byte_discarded", 64'(line_clean), 64'd1);

      // One more frame after reset to confirm normal operation resumes.
      applyStimulus(vecs[0], 6);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
